// File: rtl/multi_window_pkg.sv
// Shared types for the multi-channel window lift controller.
// Channel state codes are visible on the top-level state bus.
package multi_window_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_MAN_UP  = 3'd1,
        ST_MAN_DN  = 3'd2,
        ST_AUTO_UP = 3'd3,
        ST_AUTO_DN = 3'd4,
        ST_REVERSE = 3'd5
    } win_state_t;

    localparam win_state_t ST_RECOVER = ST_IDLE;

endpackage

// File: rtl/window_channel.sv
// One window channel: travel FSM, position counter, tap timer,
// anti-pinch reverse counter and button edge detect.
module window_channel
    import multi_window_pkg::*;
#(
    parameter int POS_W    = 4,
    parameter int POS_MAX  = 15,
    parameter int TAP_CYC  = 4,
    parameter int REV_DIST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_lock,
    input  logic               i_up,
    input  logic               i_dn,
    input  logic               i_pinch,
    output logic               o_motor_up,
    output logic               o_motor_dn,
    output logic [POS_W-1:0]   o_pos,
    output logic [STATE_W-1:0] o_state
);

    localparam int HW = $clog2(TAP_CYC + 1);
    localparam int RW = $clog2(REV_DIST + 1);
    localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_ONE  = POS_W'(1);
    localparam logic [HW-1:0]    H_TAP  = HW'(TAP_CYC);
    localparam logic [RW-1:0]    R_LAST = RW'(REV_DIST - 1);

    win_state_t       r_state;
    logic [POS_W-1:0] r_pos;
    logic [HW-1:0]    r_hold;
    logic [RW-1:0]    r_rev;
    logic             r_up_q;
    logic             r_dn_q;

    logic             w_both;
    logic             w_edge;
    logic             w_top;
    logic             w_bot;
    logic [POS_W-1:0] w_pos_inc;
    logic [POS_W-1:0] w_pos_dec;

    assign w_both    = i_up & i_dn;
    assign w_edge    = (i_up & ~r_up_q) | (i_dn & ~r_dn_q);
    assign w_top     = i_tick & (r_pos == P_MAX - P_ONE);
    assign w_bot     = i_tick & (r_pos == P_ONE);
    assign w_pos_inc = (r_pos < P_MAX) ? r_pos + P_ONE : r_pos;
    assign w_pos_dec = (r_pos != '0) ? r_pos - P_ONE : r_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_hold  <= '0;
            r_rev   <= '0;
            r_up_q  <= 1'b0;
            r_dn_q  <= 1'b0;
        end else begin
            r_up_q <= i_up;
            r_dn_q <= i_dn;
            case (r_state)
                ST_IDLE: begin
                    if (!i_lock) begin
                        if (i_up && !i_dn && r_pos < P_MAX) begin
                            r_state <= ST_MAN_UP;
                            r_hold  <= '0;
                        end else if (i_dn && !i_up && r_pos != '0) begin
                            r_state <= ST_MAN_DN;
                            r_hold  <= '0;
                        end
                    end
                end
                // pinch freezes the position and beats every other exit
                ST_MAN_UP, ST_AUTO_UP: begin
                    if (i_pinch) begin
                        r_state <= ST_REVERSE;
                        r_rev   <= '0;
                    end else begin
                        if (i_tick) r_pos <= w_pos_inc;
                        if (i_lock || w_both || w_top) begin
                            r_state <= ST_IDLE;
                        end else if (r_state == ST_AUTO_UP) begin
                            if (w_edge) r_state <= ST_IDLE;
                        end else if (i_up) begin
                            if (r_hold < H_TAP) r_hold <= r_hold + 1'b1;
                        end else begin
                            r_state <= (r_hold < H_TAP) ? ST_AUTO_UP : ST_IDLE;
                        end
                    end
                end
                ST_MAN_DN, ST_AUTO_DN: begin
                    if (i_tick) r_pos <= w_pos_dec;
                    if (i_lock || w_both || w_bot) begin
                        r_state <= ST_IDLE;
                    end else if (r_state == ST_AUTO_DN) begin
                        if (w_edge) r_state <= ST_IDLE;
                    end else if (i_dn) begin
                        if (r_hold < H_TAP) r_hold <= r_hold + 1'b1;
                    end else begin
                        r_state <= (r_hold < H_TAP) ? ST_AUTO_DN : ST_IDLE;
                    end
                end
                ST_REVERSE: begin
                    if (r_pos == '0) begin
                        r_state <= ST_IDLE;
                    end else if (i_tick) begin
                        r_pos <= w_pos_dec;
                        r_rev <= r_rev + 1'b1;
                        if (r_rev >= R_LAST || r_pos == P_ONE) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_RECOVER;
            endcase
        end
    end

    assign o_motor_up = (r_state == ST_MAN_UP) | (r_state == ST_AUTO_UP);
    assign o_motor_dn = (r_state == ST_MAN_DN) | (r_state == ST_AUTO_DN)
                      | (r_state == ST_REVERSE);
    assign o_pos      = r_pos;
    assign o_state    = r_state;

endmodule

// File: rtl/multi_window_ctrl.sv
// NUM_WIN window channels; the child lock gates every channel but 0.
module multi_window_ctrl
    import multi_window_pkg::*;
#(
    parameter int NUM_WIN  = 4,
    parameter int POS_W    = 4,
    parameter int POS_MAX  = 15,
    parameter int TAP_CYC  = 4,
    parameter int REV_DIST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       lock,
    input  logic [NUM_WIN-1:0]         btn_up,
    input  logic [NUM_WIN-1:0]         btn_dn,
    input  logic [NUM_WIN-1:0]         pinch,
    output logic [NUM_WIN-1:0]         motor_up,
    output logic [NUM_WIN-1:0]         motor_dn,
    output logic [NUM_WIN*POS_W-1:0]   pos,
    output logic [NUM_WIN*STATE_W-1:0] state
);

    for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
        logic w_lock;
        assign w_lock = (k == 0) ? 1'b0 : lock;

        window_channel #(
            .POS_W    (POS_W),
            .POS_MAX  (POS_MAX),
            .TAP_CYC  (TAP_CYC),
            .REV_DIST (REV_DIST)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_tick     (tick),
            .i_lock     (w_lock),
            .i_up       (btn_up[k]),
            .i_dn       (btn_dn[k]),
            .i_pinch    (pinch[k]),
            .o_motor_up (motor_up[k]),
            .o_motor_dn (motor_dn[k]),
            .o_pos      (pos[k*POS_W +: POS_W]),
            .o_state    (state[k*STATE_W +: STATE_W])
        );
    end

endmodule

// File: tb/tb_multi_window_ctrl.sv
// Bench for multi_window_ctrl: vector table, directed corner sequences
// and a random run against a behavioural channel model.
module tb_multi_window_ctrl;

    localparam int NW   = 4;
    localparam int PW   = 4;
    localparam int PMAX = 15;
    localparam int TAP  = 4;
    localparam int REV  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic lock = 1'b0;
    logic [NW-1:0] btn_up = '0;
    logic [NW-1:0] btn_dn = '0;
    logic [NW-1:0] pinch = '0;
    logic [NW-1:0] motor_up;
    logic [NW-1:0] motor_dn;
    logic [NW*PW-1:0] pos;
    logic [NW*3-1:0] state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multi_window_ctrl #(
        .NUM_WIN(NW), .POS_W(PW), .POS_MAX(PMAX),
        .TAP_CYC(TAP), .REV_DIST(REV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .lock(lock),
        .btn_up(btn_up), .btn_dn(btn_dn), .pinch(pinch),
        .motor_up(motor_up), .motor_dn(motor_dn),
        .pos(pos), .state(state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int st_of(int k);
        return int'(state[k*3 +: 3]);
    endfunction

    function automatic int pos_of(int k);
        return int'(pos[k*PW +: PW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: travel mode plus signed direction per channel
    localparam int M_IDLE = 0;
    localparam int M_MAN  = 1;
    localparam int M_AUTO = 2;
    localparam int M_REV  = 3;

    typedef struct {
        int pos;
        int mode;
        int dir;
        int held;
        int rev_left;
        bit pu;
        bit pd;
    } ch_t;

    ch_t m[NW];

    function automatic void m_reset();
        for (int k = 0; k < NW; k++) m[k] = '{default: 0};
    endfunction

    function automatic void m_step(int k, bit u, bit d, bit p, bit t, bit l);
        ch_t c = m[k];
        bit both = u && d;
        bit rise = (u && !c.pu) || (d && !c.pd);
        bit stop = 1'b0;
        c.pu = u;
        c.pd = d;
        if (c.mode == M_IDLE) begin
            if (!l && u && !d && c.pos < PMAX) begin
                c.mode = M_MAN; c.dir = 1; c.held = 0;
            end else if (!l && d && !u && c.pos > 0) begin
                c.mode = M_MAN; c.dir = -1; c.held = 0;
            end
        end else if (c.mode == M_REV) begin
            if (c.pos == 0) c.mode = M_IDLE;
            else if (t) begin
                c.pos--;
                c.rev_left--;
                if (c.rev_left == 0 || c.pos == 0) c.mode = M_IDLE;
            end
        end else if (c.dir > 0 && p) begin
            c.mode = M_REV;
            c.rev_left = REV;
        end else begin
            if (t) begin
                c.pos += c.dir;
                if (c.pos == ((c.dir > 0) ? PMAX : 0)) stop = 1'b1;
            end
            if (l || both) stop = 1'b1;
            if (!stop && c.mode == M_MAN) begin
                if ((c.dir > 0) ? u : d) c.held = (c.held < TAP) ? c.held + 1 : TAP;
                else if (c.held < TAP) c.mode = M_AUTO;
                else stop = 1'b1;
            end else if (!stop && rise) begin
                stop = 1'b1;
            end
            if (stop) c.mode = M_IDLE;
        end
        m[k] = c;
    endfunction

    function automatic int m_code(int k);
        case (m[k].mode)
            M_IDLE:  return 0;
            M_MAN:   return (m[k].dir > 0) ? 1 : 2;
            M_AUTO:  return (m[k].dir > 0) ? 3 : 4;
            default: return 5;
        endcase
    endfunction

    task automatic do_reset();
        btn_up = '0; btn_dn = '0; pinch = '0; lock = 1'b0; tick = 1'b1;
        rst_n = 1'b0;
        #3;
        chk("reset state", int'(state), 0);
        chk("reset pos", int'(pos), 0);
        chk("reset motors", int'({motor_up, motor_dn}), 0);
        step();
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        bit up;
        bit dn;
        bit tk;
        int st;
        int ps;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit u, bit d, bit t, int s, int p);
        vec_t v;
        v.up = u; v.dn = d; v.tk = t; v.st = s; v.ps = p;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;

        // channel 0 vector table
        add(0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 1, 1, i);
        add(0, 0, 1, 0, 6);
        add(1, 0, 1, 1, 6);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 6);
        add(0, 0, 0, 0, 6);
        add(0, 1, 1, 2, 6);
        add(0, 1, 1, 2, 5);
        add(1, 1, 1, 0, 4);
        add(0, 0, 1, 0, 4);
        add(1, 0, 1, 1, 4);
        for (int p = 5; p < 15; p++) add(1, 0, 1, 1, p);
        add(1, 0, 1, 0, 15);
        add(1, 0, 1, 0, 15);
        add(0, 0, 1, 0, 15);

        do_reset();
        foreach (tbl[i]) begin
            btn_up[0] = tbl[i].up;
            btn_dn[0] = tbl[i].dn;
            tick = tbl[i].tk;
            step();
            chk($sformatf("vec%0d state", i), st_of(0), tbl[i].st);
            chk($sformatf("vec%0d pos", i), pos_of(0), tbl[i].ps);
            chk($sformatf("vec%0d motor_up", i), int'(motor_up[0]),
                (tbl[i].st == 1 || tbl[i].st == 3) ? 1 : 0);
            chk($sformatf("vec%0d motor_dn", i), int'(motor_dn[0]),
                (tbl[i].st == 2 || tbl[i].st == 4 || tbl[i].st == 5) ? 1 : 0);
        end

        // tap down from pos 10 on channel 1
        do_reset();
        btn_up[1] = 1'b1;
        repeat (10) step();
        btn_up[1] = 1'b0;
        step();
        chk("B pos10", pos_of(1), 10);
        chk("B idle", st_of(1), 0);
        btn_dn[1] = 1'b1;
        repeat (2) step();
        btn_dn[1] = 1'b0;
        step();
        chk("B auto_dn", st_of(1), 4);
        chk("B pos8", pos_of(1), 8);
        n = 0;
        while (pos_of(1) != 0 && n < 40) begin
            chk("B motor_dn on", int'(motor_dn[1]), 1);
            step();
            n++;
        end
        chk("B cycles", n, 8);
        chk("B end idle", st_of(1), 0);
        chk("B motor_dn off", int'(motor_dn[1]), 0);

        // pinch on channel 2 during auto up
        do_reset();
        btn_up[2] = 1'b1;
        repeat (3) step();
        btn_up[2] = 1'b0;
        step();
        chk("C auto_up", st_of(2), 3);
        chk("C pos3", pos_of(2), 3);
        repeat (6) step();
        chk("C pos9", pos_of(2), 9);
        pinch[2] = 1'b1;
        step();
        pinch[2] = 1'b0;
        chk("C reverse", st_of(2), 5);
        chk("C pinch pos", pos_of(2), 9);
        btn_up[2] = 1'b1;
        btn_dn[2] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("C rev pos%0d", i), pos_of(2), 9 - i);
            chk($sformatf("C rev st%0d", i), st_of(2), (i < 4) ? 5 : 0);
        end
        btn_up[2] = 1'b0;
        btn_dn[2] = 1'b0;
        step();
        chk("C final pos", pos_of(2), 5);
        chk("C final st", st_of(2), 0);

        // child lock with channels 0 and 3 in auto up
        do_reset();
        btn_up[0] = 1'b1;
        btn_up[3] = 1'b1;
        repeat (3) step();
        btn_up = '0;
        step();
        chk("D ch0 auto", st_of(0), 3);
        chk("D ch3 auto", st_of(3), 3);
        lock = 1'b1;
        step();
        chk("D ch3 locked", st_of(3), 0);
        chk("D ch3 pos", pos_of(3), 4);
        chk("D ch0 runs", st_of(0), 3);
        btn_up[3] = 1'b1;
        n = 0;
        while (st_of(0) != 0 && n < 30) begin
            step();
            n++;
            chk("D ch3 ignores btn", st_of(3), 0);
        end
        chk("D ch0 cycles", n, 11);
        chk("D ch0 top", pos_of(0), 15);
        chk("D ch3 held", pos_of(3), 4);
        btn_up[3] = 1'b0;
        lock = 1'b0;

        // reset in the middle of auto up
        do_reset();
        btn_up[0] = 1'b1;
        repeat (2) step();
        btn_up[0] = 1'b0;
        step();
        repeat (5) step();
        chk("F pos7", pos_of(0), 7);
        chk("F motor on", int'(motor_up[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F motors off", int'({motor_up, motor_dn}), 0);
        chk("F pos0", int'(pos), 0);
        chk("F idle", int'(state), 0);
        step();
        rst_n = 1'b1;

        // randomized run against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 7) == 0) btn_up[k] = ~btn_up[k];
                if ($urandom_range(0, 7) == 0) btn_dn[k] = ~btn_dn[k];
                pinch[k] = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 49) == 0) lock = ~lock;
            tick = ($urandom_range(0, 4) != 0);
            step();
            for (int k = 0; k < NW; k++) begin
                m_step(k, btn_up[k], btn_dn[k], pinch[k], tick,
                       (k == 0) ? 1'b0 : lock);
                chk($sformatf("rnd%0d ch%0d state", cyc, k), st_of(k), m_code(k));
                chk($sformatf("rnd%0d ch%0d pos", cyc, k), pos_of(k), m[k].pos);
                chk($sformatf("rnd%0d ch%0d motor_up", cyc, k), int'(motor_up[k]),
                    (m[k].mode inside {M_MAN, M_AUTO} && m[k].dir > 0) ? 1 : 0);
                chk($sformatf("rnd%0d ch%0d motor_dn", cyc, k), int'(motor_dn[k]),
                    (m[k].mode == M_REV ||
                     (m[k].mode inside {M_MAN, M_AUTO} && m[k].dir < 0)) ? 1 : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_window_ctrl.md
Name: multi_window_ctrl

Overview:
- Parametrised successor to the single-window controller: NUM_WIN independent window channels.
- Each channel has a position counter, manual and one-touch (auto) travel in both directions, end-stop limits, anti-pinch reversal, and a global child lock on the non-driver channels.
- Sits between the debounced door-switch inputs and the motor drivers.
- Outputs are Moore, decoded from registered state.

Parameters:
- NUM_WIN, 4: number of window channels, 1..8.
- POS_W, 4: position counter width.
- POS_MAX, 15: fully-closed position; 0 is fully open; POS_MAX <= 2^POS_W-1.
- TAP_CYC, 4: clk cycles; a press released before this count is a tap and triggers auto travel.
- REV_DIST, 4: position steps travelled downward after a pinch.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  motor step strobe; position moves one step per cycle in which tick=1 and the motor is active.
- lock  in  1  child lock; 1 disables buttons on channels 1..NUM_WIN-1.
- btn_up  in  NUM_WIN  close request per channel.
- btn_dn  in  NUM_WIN  open request per channel.
- pinch  in  NUM_WIN  obstruction sensor per channel.
- motor_up  out  NUM_WIN  drive closing.
- motor_dn  out  NUM_WIN  drive opening.
- pos  out  NUM_WIN*POS_W  channel k position at [k*POS_W +: POS_W].
- state  out  NUM_WIN*3  channel k state encoding at [k*3 +: 3].

Behaviour:
- Reset (async, rst_n=0), every channel: state=IDLE, pos=0, hold counter=0, reverse counter=0. motor_up=motor_dn=0 throughout reset.
- States:
  - IDLE=0
  - MAN_UP=1
  - MAN_DN=2
  - AUTO_UP=3
  - AUTO_DN=4
  - REVERSE=5
  - Codes 6-7 are illegal and recover to IDLE next cycle.
- Motor outputs:
  - motor_up=1 iff state in {MAN_UP, AUTO_UP}.
  - motor_dn=1 iff state in {MAN_DN, AUTO_DN, REVERSE}.
  - Never both 1.
- Button priority: both btn_up and btn_dn high is treated as "stop" in every button-sensitive state.
- IDLE:
  - up-only and pos<POS_MAX -> MAN_UP, hold counter=0.
  - dn-only and pos>0 -> MAN_DN, hold counter=0.
  - Otherwise stay.
  - A request toward an end stop the window is already at is ignored.
- MAN_UP / MAN_DN:
  - Hold counter increments each clk, saturating at TAP_CYC.
  - Button still held: stay.
  - Button released with counter<TAP_CYC: go to AUTO_UP / AUTO_DN.
  - Button released with counter>=TAP_CYC: go to IDLE.
  - Both buttons pressed: go to IDLE.
- AUTO_UP / AUTO_DN:
  - A rising edge on either button of the channel -> IDLE.
  - The releasing press that entered auto is not an edge.
- End stops:
  - In an up state, tick with pos==POS_MAX-1: pos becomes POS_MAX and state -> IDLE on the same edge.
  - In a down state (not REVERSE), tick with pos==1: pos becomes 0 and state -> IDLE on the same edge.
  - pos never wraps; it saturates in [0, POS_MAX].
- Pinch:
  - pinch=1 in MAN_UP or AUTO_UP -> REVERSE, reverse counter=0. Pinch has priority over buttons and over the end stop.
  - Pinch is ignored in other states.
- REVERSE:
  - Buttons are ignored.
  - Each tick decrements pos and increments the reverse counter.
  - Exit to IDLE when the counter reaches REV_DIST or pos reaches 0, whichever is first.
- Lock:
  - When lock=1, channels >=1 in MAN_* or AUTO_* go to IDLE next edge, and IDLE ignores buttons.
  - REVERSE always completes.
  - Channel 0 is never locked.
- Pos updates only on tick. A state transition and a pos step on the same edge both take effect.
- Reset asserted mid-travel stops the motor immediately (async) and returns pos to 0.

Decomposition:
- Package multi_window_pkg holds:
  - win_state_t enum with the six codes above.
  - STATE_W=3.
  - The illegal-code recovery constant.
- Sub-module window_channel holds one channel's FSM, pos counter, hold/reverse counters and button edge detect.
- The top generates NUM_WIN instances, applies lock to instances 1..NUM_WIN-1, and packs outputs.

Test Plan (defaults, tick=1 every cycle unless stated):
- Hold btn_up[0] for 6 cycles then release -> MAN_UP, motor_up[0]=1, pos 0->6, then IDLE with pos=6.
- Tap btn_dn[1] 2 cycles from pos=10 -> AUTO_DN, pos counts to 0, IDLE with motor_dn[1]=0 on the edge pos reaches 0.
- AUTO_UP from pos=3, assert pinch[2] at pos=9 -> REVERSE, pos 9->5 over 4 ticks, then IDLE. Buttons pressed during REVERSE have no effect.
- AUTO_UP on channels 0 and 3, raise lock -> channel 3 IDLE next edge, channel 0 continues to pos=15. btn_up[3] ignored while lock=1.
- Pos=15 with btn_up held -> stays IDLE, motor_up=0. Both buttons in MAN_DN -> IDLE. Tick=0 for 5 cycles in MAN_UP -> pos unchanged.
- Assert rst_n=0 mid AUTO_UP at pos=7 -> motors 0 immediately, pos=0, state=IDLE for all channels.
